ps2_key_rx: RTL

//  PS/2 keyboard front end for LALU: syncs raw PS2_CLK/PS2_DAT pins, deframes 11-bit device->host frames,

---
 rtl/ps2_key_rx_pkg.sv | 32 +++
 rtl/ps2_key_rx_frame_rx.sv | 145 ++++++++++++++
 rtl/ps2_key_rx.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ps2_key_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame FSM states,
// scancode prefix bytes and the packed key-event layout {ext, brk, code}.
package ps2_key_rx_pkg;

  typedef enum logic [1:0] {
    FR_IDLE   = 2'd0,
    FR_DATA   = 2'd1,
    FR_PARITY = 2'd2,
    FR_STOP   = 2'd3
  } frame_state_e;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  localparam int EVT_CODE_W   = 8;
  localparam int EVT_CODE_LSB = 0;
  localparam int EVT_BRK_BIT  = 8;
  localparam int EVT_EXT_BIT  = 9;
  localparam int EVT_W        = 10;

  typedef logic [EVT_W-1:0] evt_t;

  function automatic evt_t pack_evt(input logic ext, input logic brk, input logic [7:0] code);
    return {ext, brk, code};
  endfunction

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_key_rx_frame_rx.sv
// PS/2 device->host frame receiver: pin synchronisers, ps2_clk glitch
// filter, falling-edge detect, 11-bit deframing and mid-frame timeout.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// FR_IDLE   | bus idle; next fall samples the start bit (must be 0)
// FR_DATA   | shifting in 8 data bits, LSB first
// FR_PARITY | capturing the parity bit
// FR_STOP   | next fall samples the stop bit, then byte or error is issued
module ps2_key_rx_frame_rx
  import ps2_key_rx_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o
);

  localparam int FILT_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [FILT_W-1:0] FILT_LOAD = FILT_W'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT_CYC);

  logic [1:0]        clk_sync_q;
  logic [1:0]        dat_sync_q;
  logic              filt_q;
  logic [FILT_W-1:0] filt_cnt_q;
  logic              fall_q;
  logic              dat_q;
  frame_state_e      state_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        shift_q;
  logic              par_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              timeout_w;

  // Two-flop synchronisers; preset high so reset looks like an idle bus.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
    end
  end

  // Glitch filter: a new clock level is accepted only after FILTER_LEN
  // consecutive differing samples; an accepted 1->0 change is a fall and
  // captures the synchronised data bit in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= FILT_LOAD;
      fall_q     <= 1'b0;
      dat_q      <= 1'b1;
    end else begin
      fall_q <= 1'b0;
      if (clk_sync_q[1] == filt_q) begin
        filt_cnt_q <= FILT_LOAD;
      end else if (filt_cnt_q == '0) begin
        filt_q     <= clk_sync_q[1];
        filt_cnt_q <= FILT_LOAD;
        if (filt_q) begin
          fall_q <= 1'b1;
          dat_q  <= dat_sync_q[1];
        end
      end else begin
        filt_cnt_q <= filt_cnt_q - 1'b1;
      end
    end
  end

  // Mid-frame idle counter: cleared on each fall and while idle, saturates.
  always_ff @(posedge clk_i) begin
    if (rst_i || state_q == FR_IDLE || fall_q) begin
      to_cnt_q <= '0;
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  // A fall arriving in the same cycle keeps the frame alive.
  assign timeout_w = (state_q != FR_IDLE) && (to_cnt_q == TO_MAX) && !fall_q;

  // Frame FSM with registered byte_valid/frame_err pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= FR_IDLE;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      byte_valid_o <= 1'b0;
      byte_o       <= '0;
      frame_err_o  <= 1'b0;
    end else begin
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      if (timeout_w) begin
        state_q     <= FR_IDLE;
        frame_err_o <= 1'b1;
      end else if (fall_q) begin
        case (state_q)
          FR_IDLE: begin
            if (!dat_q) begin
              state_q   <= FR_DATA;
              bit_idx_q <= '0;
            end else begin
              frame_err_o <= 1'b1;
            end
          end
          FR_DATA: begin
            shift_q   <= {dat_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) begin
              state_q <= FR_PARITY;
            end
          end
          FR_PARITY: begin
            par_q   <= dat_q;
            state_q <= FR_STOP;
          end
          FR_STOP: begin
            state_q <= FR_IDLE;
            if (dat_q && odd_parity_ok(shift_q, par_q)) begin
              byte_valid_o <= 1'b1;
              byte_o       <= shift_q;
            end else begin
              frame_err_o <= 1'b1;
            end
          end
          default: state_q <= FR_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard front end: receives bytes from the frame receiver, folds
// E0/F0 prefixes into key events and queues them in a small FIFO read
// through a valid/ready handshake.
module ps2_key_rx
  import ps2_key_rx_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       evt_valid_o,
  input  logic       evt_ready_i,
  output logic [7:0] evt_code_o,
  output logic       evt_break_o,
  output logic       evt_ext_o,
  output logic       frame_err_o,
  output logic       overflow_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic             byte_valid_w;
  logic [7:0]       byte_w;
  logic             frame_err_w;

  logic             ext_pend_q;
  logic             brk_pend_q;
  logic             push_q;
  evt_t             push_evt_q;

  evt_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             overflow_q;
  logic             full_w;
  logic             pop_w;
  logic             wr_en_w;
  evt_t             head_w;

  ps2_key_rx_frame_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame_rx (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ps2_clk_i    (ps2_clk_i),
    .ps2_dat_i    (ps2_dat_i),
    .byte_valid_o (byte_valid_w),
    .byte_o       (byte_w),
    .frame_err_o  (frame_err_w)
  );

  // Prefix fold: E0/F0 only arm flags; any other byte becomes one event.
  // A bad frame discards any half-built prefix sequence.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      push_q     <= 1'b0;
      push_evt_q <= '0;
    end else begin
      push_q <= 1'b0;
      if (frame_err_w) begin
        ext_pend_q <= 1'b0;
        brk_pend_q <= 1'b0;
      end else if (byte_valid_w) begin
        if (byte_w == PS2_PFX_EXT) begin
          ext_pend_q <= 1'b1;
        end else if (byte_w == PS2_PFX_BRK) begin
          brk_pend_q <= 1'b1;
        end else begin
          push_q     <= 1'b1;
          push_evt_q <= pack_evt(ext_pend_q, brk_pend_q, byte_w);
          ext_pend_q <= 1'b0;
          brk_pend_q <= 1'b0;
        end
      end
    end
  end

  assign full_w      = (count_q == CNT_W'(FIFO_DEPTH));
  assign evt_valid_o = (count_q != '0);
  assign pop_w       = evt_valid_o & evt_ready_i;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en_w     = push_q & (!full_w | pop_w);

  // Occupancy next-state.
  always_comb begin
    count_d = count_q;
    case ({wr_en_w, pop_w})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk_i) begin
    if (wr_en_w) begin
      mem_q[wr_ptr_q] <= push_evt_q;
    end
  end

  // FIFO pointers, occupancy and the overflow pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= push_q & full_w & !pop_w;
      count_q    <= count_d;
      if (wr_en_w) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_w) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  assign head_w      = evt_valid_o ? mem_q[rd_ptr_q] : '0;
  assign evt_code_o  = head_w[EVT_CODE_LSB +: EVT_CODE_W];
  assign evt_break_o = head_w[EVT_BRK_BIT];
  assign evt_ext_o   = head_w[EVT_EXT_BIT];
  assign frame_err_o = frame_err_w;
  assign overflow_o  = overflow_q;

endmodule
